// File: rtl/mcu_uart_tx_pkg.sv
// Shared constants for the MCU UART transmitter slice.
//   - TX_* : 2-bit FSM state encodings (IDLE/START/DATA/STOP)
//   - DEF_CLK_DIV / DEF_FIFO_DEPTH : default baud divider and FIFO size
//   - frame_cycles() : cycles in one 8N1 frame for a given divider
package mcu_uart_tx_pkg;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // 100 MHz system clock / 115200 baud
  localparam int DEF_CLK_DIV    = 868;
  localparam int DEF_FIFO_DEPTH = 4;

  // One start bit, eight data bits, one stop bit.
  function automatic int frame_cycles(input int clk_div);
    return 10 * clk_div;
  endfunction

endpackage

// File: rtl/mcu_uart_tx_fifo.sv
// mcu_sync_fifo: single-clock FIFO, reusable for any byte stream.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request and data; ignored while full
//   pop          : read request; ignored while empty
//   rdata        : head entry (combinational read of the head slot)
//   full, empty  : occupancy flags
//   count        : number of stored entries (one bit wider than the pointers)
// Handshake: a push is accepted only when push=1 and full=0 in the same cycle;
// a pop is accepted only when pop=1 and empty=0. A simultaneous pop never
// frees room for a push issued while full.
module mcu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-two depth: wraps naturally
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mcu_uart_tx.sv
// mcu_uart_tx: buffers every MCU OUT_PORT write and serializes it as 8N1 UART
// on TX, LSB first.
// Ports:
//   CLK, RST_N    : clock, asynchronous active-low reset (TX forced high at once)
//   OUT_PORT      : byte written by the MCU, sampled only when OUT_WE=1
//   OUT_WE        : one-cycle write strobe
//   OVF_CLR       : clears the sticky OVF flag (a same-cycle overflow wins)
//   TX            : serial line, registered, idles high
//   BUSY          : 1 while a frame (START..STOP) is in progress
//   FULL, EMPTY   : FIFO occupancy flags
//   OVF           : sticky, a write was dropped because the FIFO was full
//   DBG_STATE     : current FSM state (TX_* encodings)
//   DBG_FIFO_CNT  : current FIFO occupancy
module mcu_uart_tx
  import mcu_uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [7:0]                    OUT_PORT,
  input  logic                          OUT_WE,
  input  logic                          OVF_CLR,
  output logic                          TX,
  output logic                          BUSY,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic                          OVF,
  output logic [1:0]                    DBG_STATE,
  output logic [$clog2(FIFO_DEPTH):0]   DBG_FIFO_CNT
);

  localparam int BW = $clog2(CLK_DIV);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic          baud_end;

  mcu_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (OUT_WE),
    .wdata (OUT_PORT),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (DBG_FIFO_CNT)
  );

  // Last cycle of the current bit period.
  assign baud_end = (baud_q == BW'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;

    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = '0;
          state_d  = TX_START;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = TX_DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            // Next bit is shift_q[1] because the shift happens this same edge.
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit: no idle gap.
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = TX_START;
            tx_d     = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Overflow set has priority over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (OUT_WE && fifo_full) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign TX        = tx_q;
  assign BUSY      = (state_q != TX_IDLE);
  assign FULL      = fifo_full;
  assign EMPTY     = fifo_empty;
  assign OVF       = ovf_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mcu_uart_tx.sv
// Directed bench for mcu_uart_tx with CLK_DIV=4, FIFO_DEPTH=4, 10 ns clock.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A background decoder samples TX mid-bit and matches bytes against exp_q.
module tb_mcu_uart_tx;
  import mcu_uart_tx_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 40;   // 10 bits * 4 cycles

  logic       CLK;
  logic       RST_N;
  logic [7:0] OUT_PORT;
  logic       OUT_WE;
  logic       OVF_CLR;
  logic       TX, BUSY, FULL, EMPTY, OVF;
  logic [1:0] DBG_STATE;
  logic [2:0] DBG_FIFO_CNT;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_frames = 0;

  logic [7:0] exp_q[$];

  mcu_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .OUT_PORT     (OUT_PORT),
    .OUT_WE       (OUT_WE),
    .OVF_CLR      (OVF_CLR),
    .TX           (TX),
    .BUSY         (BUSY),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .OVF          (OVF),
    .DBG_STATE    (DBG_STATE),
    .DBG_FIFO_CNT (DBG_FIFO_CNT)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- TX decoder / scoreboard ----------------
  logic       dec_active = 1'b0;
  int         dec_idx    = 0;
  logic [7:0] dec_byte   = '0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (TX == 1'b0) begin
        dec_active = 1'b1;
        dec_idx    = 0;
      end
    end else begin
      dec_idx++;
      if (dec_idx == 2) begin
        check("dec_start_bit", {31'd0, TX}, 32'd0);
      end else if (dec_idx >= 6 && dec_idx <= 34 && (dec_idx % 4) == 2) begin
        dec_byte[(dec_idx - 6) / 4] = TX;
      end else if (dec_idx == 38) begin
        check("dec_stop_bit", {31'd0, TX}, 32'd1);
        n_frames++;
        if (exp_q.size() == 0) begin
          check("dec_unexpected_frame", 32'd1, 32'd0);
        end else begin
          check("dec_byte", {24'd0, dec_byte}, {24'd0, exp_q.pop_front()});
        end
        dec_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while ((BUSY || !EMPTY || dec_active) && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    check(tag, {31'd0, (n < max_cycles)}, 32'd1);
  endtask

  // Six strobes on consecutive cycles; the last one optionally with OVF_CLR.
  // Returns on the falling edge right after the sixth write edge.
  task automatic burst6(input logic [7:0] base, input logic clr_last);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i == 5) begin
        check("burst_full_before_6th", {31'd0, FULL}, 32'd1);
        check("burst_ovf_before_6th", {31'd0, OVF}, 32'd0);
        OVF_CLR = clr_last;
      end
      OUT_WE   = 1'b1;
      OUT_PORT = base + 8'(i + 1);
    end
    @(negedge CLK);
    OUT_WE   = 1'b0;
    OVF_CLR  = 1'b0;
    OUT_PORT = 8'h00;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [9:0] frame_bits;
    int busy_cycles;
    int low_cycles;

    RST_N    = 1'b0;
    OUT_PORT = 8'h00;
    OUT_WE   = 1'b0;
    OVF_CLR  = 1'b0;

    // 1: reset values, then idle line
    #15;
    check("rst_tx",    {31'd0, TX},    32'd1);
    check("rst_busy",  {31'd0, BUSY},  32'd0);
    check("rst_empty", {31'd0, EMPTY}, 32'd1);
    check("rst_full",  {31'd0, FULL},  32'd0);
    check("rst_ovf",   {31'd0, OVF},   32'd0);
    check("rst_state", {30'd0, DBG_STATE}, {30'd0, TX_IDLE});
    #5 RST_N = 1'b1;
    low_cycles = 0;
    repeat (5) begin
      @(negedge CLK);
      if (TX !== 1'b1) low_cycles++;
    end
    check("idle_tx_high", low_cycles, 0);

    // 2: single byte 0x55, bit-accurate timing
    exp_q.push_back(8'h55);
    @(negedge CLK);
    OUT_WE = 1'b1; OUT_PORT = 8'h55;
    @(negedge CLK);                       // after push edge E0
    OUT_WE = 1'b0; OUT_PORT = 8'h00;
    check("e0_empty", {31'd0, EMPTY}, 32'd0);
    check("e0_tx",    {31'd0, TX},    32'd1);
    check("e0_busy",  {31'd0, BUSY},  32'd0);
    @(negedge CLK);                       // after pop edge E1, idx 0
    check("e1_tx",    {31'd0, TX},    32'd0);
    check("e1_busy",  {31'd0, BUSY},  32'd1);
    check("e1_empty", {31'd0, EMPTY}, 32'd1);
    frame_bits = 10'b1_01010101_0;        // stop, data MSB..LSB, start
    repeat (2) @(negedge CLK);            // idx 2
    for (int k = 0; k < 10; k++) begin
      check($sformatf("b55_bit%0d", k), {31'd0, TX}, {31'd0, frame_bits[k]});
      if (k < 9) repeat (4) @(negedge CLK);
    end
    @(negedge CLK);                       // idx 39
    check("b55_busy_last", {31'd0, BUSY}, 32'd1);
    @(negedge CLK);                       // idx 40
    check("b55_busy_end", {31'd0, BUSY},  32'd0);
    check("b55_empty",    {31'd0, EMPTY}, 32'd1);
    check("b55_tx_idle",  {31'd0, TX},    32'd1);

    // 3: burst A1..A6, A6 dropped, five frames back-to-back
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'hA0 + 8'(i));
    burst6(8'hA0, 1'b0);                  // now after E5
    check("burst_full", {31'd0, FULL}, 32'd1);
    check("burst_ovf",  {31'd0, OVF},  32'd1);
    check("burst_cnt",  {29'd0, DBG_FIFO_CNT}, 32'd4);
    busy_cycles = 5;                      // falling edges after E1..E5
    while (BUSY && busy_cycles < 400) begin
      @(negedge CLK);
      if (BUSY) busy_cycles++;
    end
    check("burst_busy_cycles", busy_cycles, 5 * FRAME);
    wait_idle("burst_idle", 100);
    check("burst_q_drained", exp_q.size(), 0);

    // 4: OVF_CLR alone clears; OVF_CLR with overflow keeps OVF set
    @(negedge CLK);
    OVF_CLR = 1'b1;
    @(negedge CLK);
    OVF_CLR = 1'b0;
    check("ovf_clr_alone", {31'd0, OVF}, 32'd0);
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'hB0 + 8'(i));
    burst6(8'hB0, 1'b1);
    check("ovf_set_wins", {31'd0, OVF}, 32'd1);
    wait_idle("clr_idle", 300);
    @(negedge CLK);
    OVF_CLR = 1'b1;
    @(negedge CLK);
    OVF_CLR = 1'b0;
    check("ovf_clr_again", {31'd0, OVF}, 32'd0);

    // 5: async reset during DATA bit 3 of 0x0F with two bytes queued
    @(negedge CLK);
    OUT_WE = 1'b1; OUT_PORT = 8'h0F;      // edge E0
    @(negedge CLK);
    OUT_PORT = 8'h11;                     // edge E1: pop 0x0F
    @(negedge CLK);
    OUT_PORT = 8'h22;                     // edge E2
    @(negedge CLK);                       // idx 1 after E1
    OUT_WE = 1'b0; OUT_PORT = 8'h00;
    check("rst5_cnt", {29'd0, DBG_FIFO_CNT}, 32'd2);
    repeat (16) @(negedge CLK);           // idx 17: middle of data bit 3
    check("rst5_state", {30'd0, DBG_STATE}, {30'd0, TX_DATA});
    check("rst5_bit3",  {31'd0, TX}, 32'd1);
    RST_N = 1'b0;
    #1;                                   // no clock edge since assertion
    check("rst5_tx",    {31'd0, TX},    32'd1);
    check("rst5_busy",  {31'd0, BUSY},  32'd0);
    check("rst5_empty", {31'd0, EMPTY}, 32'd1);
    check("rst5_full",  {31'd0, FULL},  32'd0);
    check("rst5_idle",  {30'd0, DBG_STATE}, {30'd0, TX_IDLE});
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    low_cycles = 0;
    busy_cycles = 0;
    repeat (60) begin
      @(negedge CLK);
      if (TX !== 1'b1) low_cycles++;
      if (BUSY !== 1'b0) busy_cycles++;
    end
    check("rst5_quiet_tx",   low_cycles,  0);
    check("rst5_quiet_busy", busy_cycles, 0);

    // 6: OUT_PORT changes right after the strobe
    exp_q.push_back(8'h3C);
    @(negedge CLK);
    OUT_WE = 1'b1; OUT_PORT = 8'h3C;
    @(negedge CLK);
    OUT_WE = 1'b0; OUT_PORT = 8'hFF;
    wait_idle("hold_idle", 100);
    check("final_q_drained", exp_q.size(), 0);
    check("final_frames", n_frames, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
